ahb_master: RTL
===============

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 8, HADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, HWDATA/HRDATA/data width.
REQ-003 SHALL have port HCLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  high in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_burst  input  1  0 = SINGLE (1 beat), 1 = INCR4 (4 beats).
REQ-009 SHALL have port cmd_addr  input  ADDR_WIDTH  start address; bits [1:0] ignored, forced 0.
REQ-010 SHALL have port wdata  input  DATA_WIDTH  current write beat data, held by user until wdata_ack.
REQ-011 SHALL have port wdata_ack  output  1  one-cycle pulse when a write beat completes; user advances wdata.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  read beat data, valid with rdata_valid.
REQ-013 SHALL have port rdata_valid  output  1  one-cycle pulse per completed read beat.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a command finishes or aborts.
REQ-015 SHALL have port err  output  1  valid with done; 1 = ERROR response received.
REQ-016 SHALL have AHB ports HADDR (ADDR_WIDTH), HWRITE (1), HTRANS (2), HSIZE (3), HBURST (3), HWDATA (DATA_WIDTH) as outputs.
REQ-017 SHALL have AHB ports HRDATA (DATA_WIDTH), HREADY (1), HRESP (2) as inputs.

Function
REQ-018 SHALL implement states IDLE, ADDR, BURST, LAST.
REQ-019 IDLE: HTRANS=IDLE; on accept, latch command, go ADDR.
REQ-020 ADDR: drive HTRANS=NONSEQ, HADDR=start, HWRITE, HSIZE=3'b010, HBURST=000 (SINGLE) or 011 (INCR4).
REQ-021 Address phase completes on a cycle with HREADY=1; data phase is the following cycle(s) until HREADY=1.
REQ-022 After ADDR completes: SINGLE -> LAST; INCR4 -> BURST.
REQ-023 BURST: drive HTRANS=SEQ, HADDR = previous + 4 (modulo 2^ADDR_WIDTH); beat N address phase overlaps beat N-1 data phase.
REQ-024 BURST -> LAST after the 4th address phase completes (2-bit beat counter).
REQ-025 LAST: HTRANS=IDLE, data phase of final beat; on HREADY=1 pulse done, go IDLE.
REQ-026 All address/control outputs SHALL hold stable while HREADY=0.
REQ-027 HWDATA SHALL equal wdata during each write data phase; wdata_ack pulses on the cycle the beat completes (HREADY=1).
REQ-028 Read: rdata <= HRDATA and rdata_valid pulses one cycle after a read data phase completes.
REQ-029 HRESP=ERROR in any data phase with HREADY=1: abort remaining beats, drive HTRANS=IDLE next cycle, pulse done with err=1, go IDLE; no further wdata_ack/rdata_valid for that command.
REQ-030 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE is ignored.
REQ-031 Latency: SINGLE with zero wait states SHALL assert done 2 cycles after acceptance; INCR4 5 cycles.

Reset
REQ-032 Reset SHALL force state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, HBURST=0, HWDATA=0, rdata=0, cmd_ready=1, wdata_ack=0, rdata_valid=0, done=0, err=0.
REQ-033 Reset mid-transfer SHALL abandon the command with no done pulse.

Structure
REQ-034 HTRANS (IDLE/BUSY/NONSEQ/SEQ), HBURST, HSIZE and HRESP (OKAY/ERROR) encodings SHALL live in shared package ahb_pkg, also used by ahb_slave.
REQ-035 Single module; no sub-module.

Verification
REQ-036 Write SINGLE addr 0x04 data 0xDEADBEEF, zero waits -> NONSEQ at 0x04, HWDATA=0xDEADBEEF next cycle, done err=0; slave reg1 = 0xDEADBEEF.
REQ-037 INCR4 write from 0x00 data 1,2,3,4 -> HADDR 0x00/04/08/0C, HTRANS NONSEQ,SEQ,SEQ,SEQ, 4 wdata_ack, done at cycle 5.
REQ-038 INCR4 read from 0x00 after REQ-037 -> rdata_valid x4 with 1,2,3,4.
REQ-039 HREADY held 0 for 3 cycles during beat 2 -> HADDR/HTRANS/HWDATA stable, completion delayed 3 cycles, data correct.
REQ-040 ERROR response on beat 2 of INCR4 read -> HTRANS=IDLE next cycle, one rdata_valid only, done with err=1.
REQ-041 INCR4 from 0xF8 (ADDR_WIDTH=8) -> HADDR 0xF8, 0xFC, 0x00, 0x04; HRESETn low mid-burst -> IDLE, no done.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings used by the AHB master and slave
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR4  = 3'b011
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        MST_IDLE  = 2'b00,
        MST_ADDR  = 2'b01,
        MST_BURST = 2'b10,
        MST_LAST  = 2'b11
    } mst_state_e;

endpackage

// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - AHB-Lite master issuing SINGLE or INCR4 word transfers from a command port
module ahb_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic                  cmd_burst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(4);

    mst_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  burst_q, burst_d;
    logic [1:0]            beat_q, beat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  data_phase, beat_ok, beat_err;

    // Every BURST/LAST cycle carries the data phase of an already-issued beat.
    always_comb begin
        data_phase = (state_q == MST_BURST) || (state_q == MST_LAST);
        beat_err   = data_phase && HREADY && (HRESP == HRESP_ERROR);
        beat_ok    = data_phase && HREADY && (HRESP != HRESP_ERROR);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rvalid_d = beat_ok && !write_q;
        rdata_d  = rvalid_d ? HRDATA : rdata_q;
        unique case (state_q)
            MST_IDLE: begin
                if (cmd_valid) begin
                    state_d = MST_ADDR;
                    addr_d  = cmd_addr & ADDR_ALIGN;
                    write_d = cmd_write;
                    burst_d = cmd_burst;
                    beat_d  = 2'd0;
                end
            end
            MST_ADDR: begin
                if (HREADY) begin
                    if (burst_q) begin
                        state_d = MST_BURST;
                        addr_d  = addr_q + ADDR_STEP;
                        beat_d  = 2'd1;
                    end else begin
                        state_d = MST_LAST;
                    end
                end
            end
            MST_BURST: begin
                if (beat_err) begin
                    state_d = MST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (HREADY) begin
                    if (beat_q == 2'd3) begin
                        state_d = MST_LAST;
                    end else begin
                        addr_d = addr_q + ADDR_STEP;
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            MST_LAST: begin
                if (HREADY) begin
                    state_d = MST_IDLE;
                    done_d  = 1'b1;
                    err_d   = beat_err;
                end
            end
            default: state_d = MST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= MST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            burst_q  <= 1'b0;
            beat_q   <= 2'd0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready   = (state_q == MST_IDLE);
    assign HTRANS      = (state_q == MST_ADDR)  ? HTRANS_NONSEQ :
                         (state_q == MST_BURST) ? HTRANS_SEQ : HTRANS_IDLE;
    assign HADDR       = addr_q;
    assign HWRITE      = write_q;
    assign HSIZE       = HSIZE_WORD;
    assign HBURST      = burst_q ? HBURST_INCR4 : HBURST_SINGLE;
    assign HWDATA      = (data_phase && write_q) ? wdata : '0;
    assign wdata_ack   = beat_ok && write_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
